// File: rtl/irrigation_pkg.sv
// Shared constants for the irrigation front end: sensor/button bit positions and
// the default debounce window used by the input conditioner.
package irrigation_pkg;

    typedef enum int {
        SENS_LOW_WATER  = 0,
        SENS_MID_WATER  = 1,
        SENS_HIGH_WATER = 2,
        SENS_EARTH_HUM  = 3,
        SENS_AIR_HUM    = 4,
        SENS_LOW_TEMP   = 5
    } sensor_idx_e;

    typedef enum int {
        BTN_PULSE_2 = 0,
        BTN_PULSE_3 = 1
    } button_idx_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

    // Counter must hold DEBOUNCE_CYCLES-1; sized with one value of headroom.
    function automatic int debounce_cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One-bit two-flop synchroniser followed by a hold-time debouncer; edge_o pulses
// for one cycle whenever the accepted (stable) level changes.
module debounce_cell
    import irrigation_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw_i,
    output logic stable_o,
    output logic edge_o
);

    localparam int             CNT_W = debounce_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             edge_q, edge_d;

    // Any cycle where s2 agrees with the accepted level restarts the hold count.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        edge_d   = 1'b0;
        if (s2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            stable_d = s2_q;
            cnt_d    = '0;
            edge_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_q     <= RESET_VALUE;
            s2_q     <= RESET_VALUE;
            cnt_q    <= '0;
            stable_q <= RESET_VALUE;
            edge_q   <= 1'b0;
        end else begin
            s1_q     <= raw_i;
            s2_q     <= s1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            edge_q   <= edge_d;
        end
    end

    assign stable_o = stable_q;
    assign edge_o   = edge_q;

endmodule

// File: rtl/sensor_input_conditioner.sv
// Debounces the field sensors and active-low buttons, producing registered levels,
// press strobes and a single any-sensor-changed strobe.
module sensor_input_conditioner
    import irrigation_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SENSOR_COUNT    = 6,
    parameter int BUTTON_COUNT    = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [SENSOR_COUNT-1:0] raw_sensors,
    input  logic [BUTTON_COUNT-1:0] raw_buttons,
    output logic [SENSOR_COUNT-1:0] sensors,
    output logic [BUTTON_COUNT-1:0] button_level,
    output logic [BUTTON_COUNT-1:0] button_press,
    output logic                    sensor_changed
);

    logic [SENSOR_COUNT-1:0] sens_stable, sens_edge;
    logic [BUTTON_COUNT-1:0] btn_stable, btn_edge;

    logic [SENSOR_COUNT-1:0] sensors_q;
    logic [BUTTON_COUNT-1:0] button_level_q, button_press_q, button_press_d;
    logic                    sensor_changed_q, sensor_changed_d;

    for (genvar i = 0; i < SENSOR_COUNT; i++) begin : g_sens
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VALUE    (1'b0)
        ) u_cell (
            .clock   (clock),
            .reset_n (reset_n),
            .raw_i   (raw_sensors[i]),
            .stable_o(sens_stable[i]),
            .edge_o  (sens_edge[i])
        );
    end

    // Buttons idle high, so their cells reset to the released level.
    for (genvar i = 0; i < BUTTON_COUNT; i++) begin : g_btn
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VALUE    (1'b1)
        ) u_cell (
            .clock   (clock),
            .reset_n (reset_n),
            .raw_i   (raw_buttons[i]),
            .stable_o(btn_stable[i]),
            .edge_o  (btn_edge[i])
        );
    end

    assign button_press_d   = btn_edge & ~btn_stable;
    assign sensor_changed_d = |sens_edge;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sensors_q        <= '0;
            button_level_q   <= '0;
            button_press_q   <= '0;
            sensor_changed_q <= 1'b0;
        end else begin
            sensors_q        <= sens_stable;
            button_level_q   <= ~btn_stable;
            button_press_q   <= button_press_d;
            sensor_changed_q <= sensor_changed_d;
        end
    end

    assign sensors        = sensors_q;
    assign button_level   = button_level_q;
    assign button_press   = button_press_q;
    assign sensor_changed = sensor_changed_q;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Directed bench for sensor_input_conditioner with DEBOUNCE_CYCLES=4: expected
// outputs are queued per cycle when stimulus is applied and compared as cycles pass.
module tb_sensor_input_conditioner;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [5:0] raw_sensors;
    logic [1:0] raw_buttons;
    logic [5:0] sensors;
    logic [1:0] button_level;
    logic [1:0] button_press;
    logic       sensor_changed;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int          cyc;
        logic [10:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];

    sensor_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .SENSOR_COUNT   (6),
        .BUTTON_COUNT   (2)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .raw_sensors   (raw_sensors),
        .raw_buttons   (raw_buttons),
        .sensors       (sensors),
        .button_level  (button_level),
        .button_press  (button_press),
        .sensor_changed(sensor_changed)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Keep the scoreboard ordered by cycle so the checker can pop from the front.
    task automatic expect_at(input int c, input logic [5:0] s, input logic [1:0] l,
                             input logic [1:0] p, input logic ch, input string tag);
        exp_t e;
        int   idx;
        e.cyc = c;
        e.val = {s, l, p, ch};
        e.tag = tag;
        idx = sb.size();
        while (idx > 0 && sb[idx-1].cyc > c) idx--;
        sb.insert(idx, e);
    endtask

    task automatic expect_span(input int from, input int to, input logic [5:0] s,
                               input logic [1:0] l, input string tag);
        for (int k = from; k <= to; k++) expect_at(k, s, l, 2'b00, 1'b0, tag);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    always @(negedge clock) begin
        exp_t        e;
        logic [10:0] obs;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            obs = {sensors, button_level, button_press, sensor_changed};
            checks++;
            assert (e.cyc == cyc && obs === e.val) else begin
                failures++;
                $error("FAIL %s cyc=%0d observed={sens,lvl,prs,chg}=%b expected=%b (due cyc %0d)",
                       e.tag, cyc, obs, e.val, e.cyc);
            end
        end
    end

    task automatic quiet_reset();
        int c;
        c = cyc;
        reset_n = 1'b0;
        raw_sensors = 6'h00;
        raw_buttons = 2'b11;
        expect_span(c + 1, c + 2, 6'h00, 2'b00, "rst_hold");
        wait_n(2);
        c = cyc;
        reset_n = 1'b1;
        expect_span(c + 1, c + 8, 6'h00, 2'b00, "rst_idle");
        wait_n(8);
    endtask

    initial begin
        int c;

        // Test 1: reset with all inputs active, then release.
        reset_n     = 1'b0;
        raw_sensors = 6'h3F;
        raw_buttons = 2'b00;
        expect_span(1, 3, 6'h00, 2'b00, "t1_in_reset");
        wait_n(3);
        c = cyc;
        reset_n = 1'b1;
        expect_span(c + 1, c + 6, 6'h00, 2'b00, "t1_latency");
        expect_at(c + 7, 6'h3F, 2'b11, 2'b11, 1'b1, "t1_update");
        expect_at(c + 8, 6'h3F, 2'b11, 2'b00, 1'b0, "t1_after");
        wait_n(8);

        quiet_reset();

        // Test 2: single sensor rise.
        c = cyc;
        raw_sensors[0] = 1'b1;
        expect_span(c + 1, c + 6, 6'h00, 2'b00, "t2_wait");
        expect_at(c + 7, 6'h01, 2'b00, 2'b00, 1'b1, "t2_rise");
        expect_at(c + 8, 6'h01, 2'b00, 2'b00, 1'b0, "t2_single");
        wait_n(8);

        // Test 3: bounce 3 high / 1 low, then steady high.
        c = cyc;
        raw_sensors[3] = 1'b1;
        expect_span(c + 1, c + 10, 6'h01, 2'b00, "t3_bounce");
        expect_at(c + 11, 6'h09, 2'b00, 2'b00, 1'b1, "t3_rise");
        expect_at(c + 12, 6'h09, 2'b00, 2'b00, 1'b0, "t3_single");
        wait_n(3);
        raw_sensors[3] = 1'b0;
        wait_n(1);
        raw_sensors[3] = 1'b1;
        wait_n(8);

        // Test 3b: a lone 3-cycle pulse is rejected.
        c = cyc;
        raw_sensors[5] = 1'b1;
        expect_span(c + 1, c + 12, 6'h09, 2'b00, "t3_short_pulse");
        wait_n(3);
        raw_sensors[5] = 1'b0;
        wait_n(9);

        // Test 4: hold pulse_3 button for 20 cycles.
        c = cyc;
        raw_buttons[1] = 1'b0;
        expect_span(c + 1, c + 6, 6'h09, 2'b00, "t4_wait");
        expect_at(c + 7, 6'h09, 2'b10, 2'b10, 1'b0, "t4_press");
        expect_span(c + 8, c + 26, 6'h09, 2'b10, "t4_held");
        expect_span(c + 27, c + 30, 6'h09, 2'b00, "t4_release");
        wait_n(20);
        raw_buttons[1] = 1'b1;
        wait_n(10);

        // Test 5: two sensors rise together.
        c = cyc;
        raw_sensors[2:1] = 2'b11;
        expect_span(c + 1, c + 6, 6'h09, 2'b00, "t5_wait");
        expect_at(c + 7, 6'h0F, 2'b00, 2'b00, 1'b1, "t5_both");
        expect_at(c + 8, 6'h0F, 2'b00, 2'b00, 1'b0, "t5_single");
        wait_n(8);

        // Test 6: reset lands on the edge that would have accepted the change.
        c = cyc;
        raw_sensors[4] = 1'b1;
        expect_span(c + 1, c + 5, 6'h0F, 2'b00, "t6_counting");
        wait_n(5);
        reset_n = 1'b0;
        expect_at(c + 6, 6'h00, 2'b00, 2'b00, 1'b0, "t6_reset");
        wait_n(1);
        reset_n = 1'b1;
        expect_span(c + 7, c + 12, 6'h00, 2'b00, "t6_relatency");
        expect_at(c + 13, 6'h1F, 2'b00, 2'b00, 1'b1, "t6_rise");
        expect_at(c + 14, 6'h1F, 2'b00, 2'b00, 1'b0, "t6_single");
        wait_n(8);

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clock);
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL drain observed_pending=%0d expected_pending=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sensor_input_conditioner.md
Name: sensor_input_conditioner

Overview:
Front-end stage feeding the irrigation top level. Synchronises and debounces the six raw field sensors (three water-level switches, earth humidity, air humidity, low temperature) and the two active-low push buttons that drive pulse_2 and pulse_3. Delivers glitch-free levels to the error checker, controller and encoders, and single-cycle press strobes to the timer reset and display/column selectors. Runs on the board clock, ahead of any clock division.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive cycles an input must hold a new value before it is accepted; legal range 1..2^20.
SENSOR_COUNT, 6, number of level-sensor inputs.
BUTTON_COUNT, 2, number of active-low push-button inputs.

Ports:
clock  input  1  board clock; all state updates on its rising edge.
reset_n  input  1  synchronous, active-low reset.
raw_sensors  input  SENSOR_COUNT  asynchronous raw sensors; bit 0 low_water, 1 mid_water, 2 high_water, 3 earth_humidity, 4 air_humidity, 5 low_temperature.
raw_buttons  input  BUTTON_COUNT  asynchronous raw buttons, active-low; bit 0 pulse_2 button, bit 1 pulse_3 button.
sensors  output  SENSOR_COUNT  debounced sensor levels, same bit order, active-high.
button_level  output  BUTTON_COUNT  debounced button state, 1 = pressed (polarity inverted from raw).
button_press  output  BUTTON_COUNT  one-cycle strobe on each debounced press (released -> pressed).
sensor_changed  output  1  one-cycle strobe when any bit of sensors changes.

Behaviour:
- Reset (reset_n low at a rising edge): synchronisers, counters and stable values cleared. sensors = 0, button_level = 0, button_press = 0, sensor_changed = 0. For buttons the synchroniser and stable state reset to the released value (raw 1). Reset mid-count discards partial counts; no strobe fires on the edge leaving reset.
- Per input, a two-flop synchroniser. The synchronised value s2 reflects a raw value 2 edges after it is first sampled.
- Per input, a counter of width clog2(DEBOUNCE_CYCLES+1) and a stable register:
  - s2 == stable: counter <= 0.
  - s2 != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0.
- Latency: a raw change held clean propagates to the output exactly 2+DEBOUNCE_CYCLES edges after the edge that first samples it. Any single-cycle return of s2 to the stable value restarts the count from 0.
- DEBOUNCE_CYCLES = 1 degenerates to synchroniser plus one register: latency 3 edges. The counter never exceeds DEBOUNCE_CYCLES-1, and the terminal comparison causes no wrap-around.
- button_press[i]: high for exactly the one cycle after button stable goes from released to pressed. Holding produces no repeats. Release produces no strobe.
- sensor_changed: high for the one cycle after any sensor stable register updates. Simultaneous updates on several bits give one strobe cycle, not several.
- Outputs are registered; no combinational path from raw inputs to outputs.
- Water-level consistency is not checked here; conflicting values pass through unchanged to the downstream checker.

Decomposition:
- Shared package irrigation_pkg holds:
  - sensor bit-index constants (SENS_LOW_WATER=0 ... SENS_LOW_TEMP=5);
  - button indices (BTN_PULSE_2=0, BTN_PULSE_3=1);
  - default DEBOUNCE_CYCLES.
- One sub-module, debounce_cell:
  - contains the synchroniser, counter and stable register for one bit;
  - has a RESET_VALUE parameter;
  - outputs stable and a one-cycle rise/fall indication.
- The top instantiates SENSOR_COUNT cells with RESET_VALUE 0 and BUTTON_COUNT cells with RESET_VALUE 1.
- Button inversion, press-strobe generation and the sensor_changed OR-reduction live in the top.

Test Plan (DEBOUNCE_CYCLES = 4):
1. Hold reset_n low 3 cycles with raw_sensors=6'b111111 and raw_buttons=2'b00 -> all outputs 0 throughout reset and on the first edge after release. sensors becomes 6'b111111 at 6 edges after release. button_level becomes 2'b11 at 6 edges after release, with one button_press=2'b11 cycle and one sensor_changed cycle.
2. From sensors=0, set raw_sensors[0]=1 and hold -> sensors[0] rises exactly 6 edges after the first sampling edge. sensor_changed pulses for 1 cycle, aligned with the update.
3. Bounce: raw_sensors[3] high for 3 cycles, low for 1, then high steadily -> no output change until 6 edges after the final rise. A 3-cycle pulse alone never changes sensors[3].
4. Press raw_buttons[1] low for 20 cycles, then release -> button_level[1] high for 20 cycles (shifted by 6). Exactly one button_press[1] strobe. No strobe on release.
5. raw_sensors[1] and raw_sensors[2] rise on the same edge -> both bits update on the same edge. sensor_changed is high for exactly 1 cycle.
6. raw_sensors[4] rises; reset_n is pulled low after 3 counted cycles -> sensors[4]=0 and no strobe. After reset release, the full 6-edge latency applies again.
